// File: rtl/result_fifo_if.sv
// Handshake bundle between the multiplier result path, the result FIFO and its reader.
// The master drives requests and write data; the slave (the FIFO) returns data and status.
interface result_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  full;
    logic                  empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;

    modport master (
        output wr_en, din, rd_en,
        input  dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/result_fifo.sv
// 8-deep synchronous FIFO for 32-bit multiplier results with registered read data
// and one-cycle ack/err pulses decoded from a registered status state.
module result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic clk,
    input  logic reset_n,
    result_fifo_if.slave bus
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR} state_t;
    // Outcome of the opposite request when both were asserted in the same cycle.
    typedef enum logic [1:0] {PEER_NONE, PEER_ACK, PEER_ERR} peer_t;

    state_t state, state_nxt;
    peer_t  peer, peer_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head, tail;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  do_wr, do_rd;

    // Occupancy alone decides acceptance; pointer equality is ambiguous between full and empty.
    assign do_wr = bus.wr_en && (count != FULL_CNT);
    assign do_rd = bus.rd_en && (count != '0);

    always_comb begin
        state_nxt = NO_OP;
        peer_nxt  = PEER_NONE;
        unique case ({bus.wr_en, bus.rd_en})
            2'b10: state_nxt = do_wr ? WRITE : WR_ERROR;
            2'b01: state_nxt = do_rd ? READ : RD_ERROR;
            2'b11: begin
                if (do_wr) begin
                    state_nxt = WRITE;
                    peer_nxt  = do_rd ? PEER_ACK : PEER_ERR;
                end else begin
                    state_nxt = READ;
                    peer_nxt  = PEER_ERR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            peer  <= PEER_NONE;
        end else begin
            state <= state_nxt;
            peer  <= peer_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            dout_q <= '0;
        end else begin
            if (do_wr)
                tail <= tail + ADDR_WIDTH'(1);
            if (do_rd) begin
                head   <= head + ADDR_WIDTH'(1);
                dout_q <= mem[head];
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[tail] <= bus.din;
    end

    assign bus.dout       = dout_q;
    assign bus.data_count = count;
    assign bus.full       = (count == FULL_CNT);
    assign bus.empty      = (count == '0);
    assign bus.wr_ack     = (state == WRITE);
    assign bus.wr_err     = (state == WR_ERROR) || (state == READ && peer == PEER_ERR);
    assign bus.rd_ack     = (state == READ) || (state == WRITE && peer == PEER_ACK);
    assign bus.rd_err     = (state == RD_ERROR) || (state == WRITE && peer == PEER_ERR);
endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo: reset, fill/drain, wrap-around, simultaneous access, single pulse.
module tb_result_fifo;
    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    result_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    result_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input logic wa, input logic we,
                              input logic ra, input logic re);
        chk({tag, "_wr_ack"}, 32'(bus.wr_ack), 32'(wa));
        chk({tag, "_wr_err"}, 32'(bus.wr_err), 32'(we));
        chk({tag, "_rd_ack"}, 32'(bus.rd_ack), 32'(ra));
        chk({tag, "_rd_err"}, 32'(bus.rd_err), 32'(re));
    endtask

    task automatic write1(input logic [31:0] d);
        bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.din = d;
        tick();
        chk("wr_ack", 32'(bus.wr_ack), 32'd1);
        bus.wr_en = 1'b0;
    endtask

    task automatic read1(input logic [31:0] exp);
        bus.wr_en = 1'b0; bus.rd_en = 1'b1;
        tick();
        chk("rd_ack", 32'(bus.rd_ack), 32'd1);
        chk("rd_dout", bus.dout, exp);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        reset_n   = 1'b0;
        #2;
        chk("rst_count", 32'(bus.data_count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, then one write too many
        for (int i = 1; i <= 8; i++) begin
            bus.wr_en = 1'b1; bus.din = 32'(i);
            tick();
            chk_pulses("fill", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("fill_count", 32'(bus.data_count), 32'(i));
            chk("fill_full", 32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
        end
        bus.din = 32'h9;
        tick();
        chk_pulses("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovf_count", 32'(bus.data_count), 32'd8);
        bus.wr_en = 1'b0;

        // Drain in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            bus.rd_en = 1'b1;
            tick();
            chk_pulses("drain", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("drain_dout", bus.dout, 32'(i));
            chk("drain_count", 32'(bus.data_count), 32'(8 - i));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        tick();
        chk_pulses("udf", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("udf_dout", bus.dout, 32'h8);
        chk("udf_count", 32'(bus.data_count), 32'd0);
        bus.rd_en = 1'b0;
        tick();
        chk_pulses("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap-around: pointers sit at 6 before the four tagged words
        for (int i = 0; i < 6; i++) write1(32'h100 + 32'(i));
        for (int i = 0; i < 6; i++) read1(32'h100 + 32'(i));
        write1(32'hA5A5A5A5);
        write1(32'h5A5A5A5A);
        write1(32'hDEADBEEF);
        write1(32'h12345678);
        chk("wrap_count4", 32'(bus.data_count), 32'd4);
        read1(32'hA5A5A5A5);
        read1(32'h5A5A5A5A);
        read1(32'hDEADBEEF);
        read1(32'h12345678);
        chk("wrap_count0", 32'(bus.data_count), 32'd0);

        // Simultaneous with 3 stored
        write1(32'h31);
        write1(32'h32);
        write1(32'h33);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 32'h34;
        tick();
        chk_pulses("both3", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("both3_count", 32'(bus.data_count), 32'd3);
        chk("both3_dout", bus.dout, 32'h31);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        read1(32'h32);
        read1(32'h33);
        read1(32'h34);

        // Simultaneous when empty: write only
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 32'h40;
        tick();
        chk_pulses("both0", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("both0_count", 32'(bus.data_count), 32'd1);
        chk("both0_dout", bus.dout, 32'h34);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;

        // Simultaneous when full: read only
        for (int i = 1; i <= 7; i++) write1(32'h40 + 32'(i));
        chk("pre8_full", 32'(bus.full), 32'd1);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 32'h99;
        tick();
        chk_pulses("both8", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("both8_count", 32'(bus.data_count), 32'd7);
        chk("both8_dout", bus.dout, 32'h40);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        for (int i = 1; i <= 7; i++) read1(32'h40 + 32'(i));
        chk("both8_empty", 32'(bus.empty), 32'd1);

        // Single-cycle fifo_write pulse from the multiplier
        bus.wr_en = 1'b1; bus.din = 32'h0000_0F0F;
        tick();
        chk_pulses("mul", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mul_count", 32'(bus.data_count), 32'd1);
        bus.wr_en = 1'b0;
        tick();
        chk_pulses("mul_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mul_count2", 32'(bus.data_count), 32'd1);
        read1(32'h0000_0F0F);
        chk("mul_count3", 32'(bus.data_count), 32'd0);

        // Asynchronous reset with 5 entries stored
        for (int i = 0; i < 5; i++) write1(32'h50 + 32'(i));
        chk("pre_rst_count", 32'(bus.data_count), 32'd5);
        bus.wr_en = 1'b1; bus.din = 32'h5F;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.data_count), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_full", 32'(bus.full), 32'd0);
        chk("arst_dout", bus.dout, 32'd0);
        chk_pulses("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.wr_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        chk_pulses("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_count", 32'(bus.data_count), 32'd0);
        bus.rd_en = 1'b0;
        write1(32'h77);
        read1(32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Synchronous FIFO that buffers 32-bit multiplier results.
- Sits between the multiplier's output-control stage, which pulses fifo_write with out_result, and the top-level result reader.
- Holds up to 8 entries and reports occupancy and full/empty status.
- Acknowledges or flags each read and write request with a one-cycle registered pulse.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request; connected to the multiplier's fifo_write.
- din  input  DATA_WIDTH  write data; connected to out_result.
- rd_en  input  1  read request from the downstream consumer.
- dout  output  DATA_WIDTH  read data, registered.
- data_count  output  ADDR_WIDTH+1  number of stored entries, 0..8.
- full  output  1  high when data_count == 8.
- empty  output  1  high when data_count == 0.
- wr_ack  output  1  pulse: previous-cycle write accepted.
- wr_err  output  1  pulse: previous-cycle write rejected because the FIFO was full.
- rd_ack  output  1  pulse: previous-cycle read accepted; dout valid this cycle.
- rd_err  output  1  pulse: previous-cycle read rejected because the FIFO was empty.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset_n low forces head = 0, tail = 0, data_count = 0, dout = 0, and all ack/err pulses = 0, immediately and independent of clk.
  - Consequently empty = 1 and full = 0 during reset.
  - Memory contents are not reset.
- Reset mid-operation: all stored data is discarded. The first rising edge after reset_n returns high behaves as on an empty FIFO.
- Status FSM (registered state, next-state from the current state and inputs):
  - States are INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. INIT is the reset state.
  - wr_en=0, rd_en=0 -> NO_OP.
  - wr_en=1, rd_en=0 -> WRITE if data_count < 8, else WR_ERROR.
  - wr_en=0, rd_en=1 -> READ if data_count > 0, else RD_ERROR.
  - Both asserted:
    - If 0 < data_count < 8, both operations are performed. State is WRITE, and both wr_ack and rd_ack pulse.
    - If empty, only the write is performed; rd_err pulses with wr_ack.
    - If full, only the read is performed; wr_err pulses with rd_ack.
  - Ack/err outputs are decoded from the registered state. Each request produces exactly one pulse, one cycle after the sampling edge.
- Write: on an accepted write, mem[tail] <= din, tail <= tail+1 mod 8.
- Read:
  - On an accepted read, dout <= mem[head] and head <= head+1 mod 8.
  - dout holds its value until the next accepted read; a rejected read leaves dout unchanged.
  - Read latency is 1 cycle: dout is valid in the same cycle that rd_ack is high.
- data_count:
  - +1 for write only, -1 for read only, unchanged when both are accepted or when neither is.
  - Never exceeds 8 or drops below 0.
- full and empty are combinational from data_count and update in the cycle after the accepted operation.
- Pointers wrap from 7 to 0. Full versus empty is distinguished solely by data_count, never by pointer equality.
- A rejected operation changes neither pointer nor data_count.

Test Plan:
- Reset state:
  - Stimulus: assert reset_n=0 mid-stream with 5 entries stored.
  - Required: data_count=0, empty=1, dout=0 without waiting for a clk edge. After release, rd_en gives rd_err=1.
- Fill to full:
  - Stimulus: write 0x00000001..0x00000008 on consecutive cycles.
  - Required: wr_ack on each write, data_count steps 1..8, full=1 after the 8th write. A 9th write gives wr_err=1 with count still 8.
- Drain and order:
  - Stimulus: read 8 times from the full FIFO.
  - Required: dout = 0x1..0x8 in order with rd_ack each cycle, then empty=1. A 9th read gives rd_err=1 and dout stays 0x8.
- Wrap-around:
  - Stimulus: write 6, read 6, then write 0xA5A5A5A5, 0x5A5A5A5A, 0xDEADBEEF, 0x12345678 (pointers wrap past 7).
  - Required: the 4 reads return those words in order and data_count returns to 0.
- Simultaneous rd_en/wr_en:
  - With count=3: data_count stays 3, wr_ack=rd_ack=1, and the oldest word appears on dout.
  - With count=0: only the write occurs, so count=1, wr_ack=1, rd_err=1.
  - With count=8: only the read occurs, so count=7, rd_ack=1, wr_err=1.
- Multiplier hookup:
  - Stimulus: drive wr_en as a single-cycle fifo_write pulse with din=0x0000_0F0F.
  - Required: exactly one entry is stored, wr_ack pulses for one cycle, and a following read returns 0x00000F0F.
